// File: rtl/ghostbus_pkg.sv
// Shared definitions for the ghostbus host: FSM state encoding and the
// width of the read-latency down-counter.
package ghostbus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        RESP
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/ghostbus_host.sv
// Ghostbus host: accepts one command at a time, issues a single-cycle bus
// strobe and, for reads and acked writes, returns one response.
import ghostbus_pkg::*;

module ghostbus_host #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 2,
    parameter int WR_ACK = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_write,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_we,
    output logic          gb_re,
    input  logic [DW-1:0] gb_rdata,
    output logic          busy
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_outOfReset;
    logic               r_write;
    logic [AW-1:0]      r_gbAddr;
    logic [DW-1:0]      r_gbWdata;
    logic               r_gbWe;
    logic               r_gbRe;
    logic               r_rspValid;
    logic               r_rspWrite;
    logic [DW-1:0]      r_rspRdata;
    logic               w_cmdReady;

    // r_outOfReset keeps cmd_ready low until the first edge after reset release
    assign w_cmdReady = (r_state == IDLE) && r_outOfReset;

    assign cmd_ready = w_cmdReady;
    assign busy      = (r_state != IDLE);
    assign gb_addr   = r_gbAddr;
    assign gb_wdata  = r_gbWdata;
    assign gb_we     = r_gbWe;
    assign gb_re     = r_gbRe;
    assign rsp_valid = r_rspValid;
    assign rsp_write = r_rspWrite;
    assign rsp_rdata = r_rspRdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_outOfReset <= 1'b0;
            r_write      <= 1'b0;
            r_gbAddr     <= '0;
            r_gbWdata    <= '0;
            r_gbWe       <= 1'b0;
            r_gbRe       <= 1'b0;
            r_rspValid   <= 1'b0;
            r_rspWrite   <= 1'b0;
            r_rspRdata   <= '0;
        end else begin
            r_outOfReset <= 1'b1;
            r_gbWe       <= 1'b0;
            r_gbRe       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid && w_cmdReady) begin
                        r_write   <= cmd_write;
                        r_gbAddr  <= cmd_addr;
                        r_gbWdata <= cmd_wdata;
                        r_gbWe    <= cmd_write;
                        r_gbRe    <= !cmd_write;
                        r_state   <= STROBE;
                    end
                end
                STROBE: begin
                    if (r_write) begin
                        if (WR_ACK != 0) begin
                            r_rspValid <= 1'b1;
                            r_rspWrite <= 1'b1;
                            r_rspRdata <= '0;
                            r_state    <= RESP;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_count <= CNT_W'(RD_LAT - 1);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // Count 0 here lands the capture RD_LAT edges after the strobe ends
                    if (r_count == '0) begin
                        r_rspValid <= 1'b1;
                        r_rspWrite <= 1'b0;
                        r_rspRdata <= gb_rdata;
                        r_state    <= RESP;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
